// File: rtl/immediate_gen_pipe_if.sv
// immediate_gen_pipe_if: handshake bundle for immediate_gen_pipe; IMM_ILLEGAL_FLAG_EN adds the illegal flags
interface immediate_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [31:0]              instr_i;
    logic [TAG_W-1:0]         tag_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [XLEN-1:0]          imm_o;
    logic [2:0]               fmt_o;
    logic [TAG_W-1:0]         tag_o;
    logic [$clog2(DEPTH):0]   count_o;
`ifdef IMM_ILLEGAL_FLAG_EN
    logic                     illegal_o;
    logic                     illegal_seen_o;
    modport slave (
        input  in_valid_i, instr_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, tag_o, count_o, illegal_o, illegal_seen_o
    );
    modport master (
        output in_valid_i, instr_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, tag_o, count_o, illegal_o, illegal_seen_o
    );
`else
    modport slave (
        input  in_valid_i, instr_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, tag_o, count_o
    );
    modport master (
        output in_valid_i, instr_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, tag_o, count_o
    );
`endif
endinterface

// File: rtl/immediate_gen_pipe.sv
// immediate_gen_pipe: RISC-V immediate decode into a DEPTH-entry FIFO; IMM_ILLEGAL_FLAG_EN adds illegal flags
module immediate_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input logic clk,
    input logic reset,
    immediate_gen_pipe_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_FLAG_EN
        logic             illegal;
`endif
    } entry_t;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          new_entry;
    entry_t          head;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [6:0]      op;
    logic [2:0]      fmt;
    logic [31:0]     ins, imm32;
    logic            push, pop, out_valid;
`ifdef IMM_ILLEGAL_FLAG_EN
    logic            seen_q, seen_d;
`endif
    always_comb begin
        ins = bus.instr_i;
        op = ins[6:0];
        fmt = (op == 7'h13 || op == 7'h03 || op == 7'h67) ? 3'd1 :
              (op == 7'h23) ? 3'd2 :
              (op == 7'h63) ? 3'd3 :
              (op == 7'h37 || op == 7'h17) ? 3'd4 :
              (op == 7'h6f) ? 3'd5 : 3'd0;
        imm32 = (fmt == 3'd1) ? {{20{ins[31]}}, ins[31:20]} :
                (fmt == 3'd2) ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                (fmt == 3'd3) ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
                (fmt == 3'd4) ? {ins[31:12], 12'b0} :
                (fmt == 3'd5) ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} : 32'b0;
        new_entry.imm = XLEN'($signed(imm32));
        new_entry.fmt = fmt;
        new_entry.tag = bus.tag_i;
`ifdef IMM_ILLEGAL_FLAG_EN
        new_entry.illegal = (fmt == 3'd0);
`endif
    end
    // readiness comes from registered count only, so a same-cycle pop never frees a full slot
    assign push      = bus.in_valid_i && (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && bus.out_ready_i;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
`ifdef IMM_ILLEGAL_FLAG_EN
        seen_d = seen_q || (push && new_entry.illegal);
`endif
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
`ifdef IMM_ILLEGAL_FLAG_EN
            seen_q <= 1'b0;
`endif
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
`ifdef IMM_ILLEGAL_FLAG_EN
            seen_q <= seen_d;
`endif
        end
    end
    assign head            = mem_q[rd_ptr_q];
    assign bus.in_ready_o  = (count_q < CW'(DEPTH));
    assign bus.out_valid_o = out_valid;
    assign bus.count_o     = count_q;
    assign bus.imm_o       = out_valid ? head.imm : '0;
    assign bus.fmt_o       = out_valid ? head.fmt : '0;
    assign bus.tag_o       = out_valid ? head.tag : '0;
`ifdef IMM_ILLEGAL_FLAG_EN
    assign bus.illegal_o      = out_valid && head.illegal;
    assign bus.illegal_seen_o = seen_q;
`endif
endmodule

// File: doc/immediate_gen_pipe.md
IMMEDIATE_GEN_PIPE -- requirements
Module: immediate_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, output queue entries; power of two, at least 2.
REQ-003 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each instruction.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid_i  input  1  instruction word present.
REQ-007 SHALL have port in_ready_o  output  1  block accepts instruction this cycle.
REQ-008 SHALL have port instr_i  input  32  full instruction word; opcode is instr_i[6:0].
REQ-009 SHALL have port tag_i  input  TAG_W  sideband tag, returned unmodified.
REQ-010 SHALL have port out_valid_o  output  1  head entry valid.
REQ-011 SHALL have port out_ready_i  input  1  consumer takes head entry.
REQ-012 SHALL have port imm_o  output  XLEN  sign-extended immediate of head entry.
REQ-013 SHALL have port fmt_o  output  3  format of head entry: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-014 SHALL have port tag_o  output  TAG_W  tag of head entry.
REQ-015 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL accept an instruction on a cycle when in_valid_i and in_ready_o are both high.
REQ-017 SHALL drive in_ready_o = (count_o < DEPTH), registered-state based, with no combinational path from out_ready_i.
REQ-018 SHALL decode the following opcodes:
  - 0x13, 0x03, 0x67 -> I: instr[31:20].
  - 0x23 -> S: {instr[31:25], instr[11:7]}.
  - 0x63 -> B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 0x37, 0x17 -> U: {instr[31:12], 12'b0}.
  - 0x6F -> J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-019 SHALL sign-extend every immediate from its bit 31 equivalent (instr[31]) to XLEN bits.
REQ-020 SHALL produce imm_o = 0 and fmt_o = 0 for any other opcode, and still queue that entry.
REQ-021 SHALL compute the immediate at accept time and store {imm, fmt, tag} in a DEPTH-entry FIFO.
REQ-022 SHALL give one-cycle latency: an entry accepted at edge N into an empty FIFO is visible on the outputs after edge N.
REQ-023 SHALL pop the head on a cycle when out_valid_o and out_ready_i are both high.
REQ-024 SHALL drive out_valid_o = (count_o != 0).
REQ-025 SHALL hold imm_o, fmt_o and tag_o stable while out_valid_o is high and out_ready_i is low.
REQ-026 SHALL, on simultaneous push and pop, leave count unchanged and keep order, including when count_o = DEPTH-1.
REQ-027 SHALL, when full, refuse the push even if a pop occurs the same cycle; in_ready_o is low for that cycle.
REQ-028 SHALL wrap read and write pointers modulo DEPTH.
REQ-029 SHALL sustain one instruction per cycle when out_ready_i is held high.
REQ-030 SHALL keep outputs deterministic when empty: imm_o, fmt_o and tag_o are 0.

Reset
REQ-031 SHALL clear pointers and count when reset is high at a clock edge, so that count_o=0, out_valid_o=0, imm_o=0, fmt_o=0, tag_o=0 and in_ready_o=1 on the next cycle.
REQ-032 SHALL discard all queued entries and ignore any handshake on a reset cycle, including mid-stream.

Configuration
REQ-033 SHALL, with macro IMM_ILLEGAL_FLAG_EN defined, add port illegal_o (output, 1), stored per entry and high for the head entry when its opcode is unsupported.
REQ-034 SHALL, with IMM_ILLEGAL_FLAG_EN defined, add port illegal_seen_o (output, 1): sticky, set on accept of an unsupported opcode, cleared only by reset.
REQ-035 SHALL, without IMM_ILLEGAL_FLAG_EN, have neither port and no associated storage.

Verification
REQ-036 SHALL check: push instr 0xFFF00093 (addi -1), tag 3, out_ready_i high -> next cycle imm_o=0xFFFFFFFF, fmt_o=1, tag_o=3.
REQ-037 SHALL check: push 0x123450B7 (lui) with XLEN=64 -> imm_o=0x0000000012345000, fmt_o=4.
REQ-038 SHALL check: push 0xFE000EE3 (beq, offset -4), then 0x0000006F -> imm_o=0xFFFFFFFC with fmt_o=3, then imm_o=0 with fmt_o=5, in order.
REQ-039 SHALL check: out_ready_i low, push DEPTH entries -> in_ready_o=0 and count_o=DEPTH; raise out_ready_i together with in_valid_i -> pop occurs, push refused, count_o=DEPTH-1.
REQ-040 SHALL check: reset asserted with 2 entries queued -> next cycle count_o=0, out_valid_o=0, in_ready_o=1.
REQ-041 SHALL check: with IMM_ILLEGAL_FLAG_EN defined, push opcode 0x7F -> illegal_o=1, fmt_o=0, imm_o=0; illegal_seen_o stays 1 after pop until reset.
